sram_write_buffer: RTL and testbench
====================================

Name: sram_write_buffer

Overview:
- Sits directly downstream of the frame encoder.
- Accepts encoded pixel writes (address + data) into a small FIFO and drives the external 16-bit asynchronous SRAM port.
- Arbitrates the single SRAM port between buffered pixel writes and display read requests; reads always have priority.
- Reports when a finished frame has been fully flushed to SRAM.

Parameters:
- ADDR_WIDTH, 20, SRAM word address width.
- DATA_WIDTH, 16, SRAM data width.
- FIFO_DEPTH, 8, write FIFO entries (power of two).
- CNT_WIDTH, 4, level counter width, equal to log2(FIFO_DEPTH)+1.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset
- i_wr_valid  in  1  pixel write request from the encoder
- o_wr_ready  out  1  FIFO not full
- i_wr_addr  in  ADDR_WIDTH  write address
- i_wr_data  in  DATA_WIDTH  write data
- i_frame_done  in  1  one-cycle pulse from the encoder when its last pixel has been issued
- i_rd_req  in  1  display read request, one word per asserted cycle
- i_rd_addr  in  ADDR_WIDTH  read address
- o_rd_data  out  DATA_WIDTH  read data
- o_rd_valid  out  1  o_rd_data valid, one-cycle pulse per read
- o_flush_done  out  1  one-cycle pulse: frame fully written
- o_fifo_level  out  CNT_WIDTH  current FIFO occupancy
- o_sram_addr  out  ADDR_WIDTH  SRAM address
- o_sram_dq_out  out  DATA_WIDTH  SRAM write data
- o_sram_dq_oe  out  1  drive DQ; the top level builds the tristate from it
- i_sram_dq_in  in  DATA_WIDTH  SRAM DQ sampled
- o_sram_we_n  out  1  write enable, active low
- o_sram_oe_n  out  1  output enable, active low
- o_sram_ce_n  out  1  chip enable, active low, tied 0 after reset
- o_sram_lb_n  out  1  lower byte enable, active low, tied 0 after reset
- o_sram_ub_n  out  1  upper byte enable, active low, tied 0 after reset

Behaviour:
- Reset: i_rst_n, asynchronous, active-low; clock i_clk.
- Reset values:
  - FIFO empty, so o_fifo_level=0 and o_wr_ready=1.
  - o_rd_valid=0, o_rd_data=0, o_flush_done=0.
  - o_sram_addr=0, o_sram_dq_out=0, o_sram_dq_oe=0.
  - o_sram_we_n=1, o_sram_oe_n=1, o_sram_ce_n=1, o_sram_lb_n=1, o_sram_ub_n=1.
  - Controller state = S_IDLE.
- Reset mid-operation discards FIFO contents and any in-flight read; no o_rd_valid is produced for it.
- Write side:
  - o_wr_ready = (level != FIFO_DEPTH), combinational from the registered level.
  - A push occurs when i_wr_valid && o_wr_ready.
  - A push with the FIFO full is impossible; i_wr_valid while not ready is held by the encoder and is not lost.
- Port arbiter, evaluated each cycle:
  - If i_rd_req: issue a read.
  - Else if the FIFO is non-empty: pop the head and issue a write.
  - Else: idle.
- Only one SRAM operation per cycle.
- All SRAM outputs are registered, so an operation decided in cycle N is driven during cycle N+1.
- Write op:
  - In N+1: o_sram_addr = head addr, o_sram_dq_out = head data, o_sram_dq_oe=1, o_sram_we_n=0, o_sram_oe_n=1.
- Read op:
  - In N+1: o_sram_addr=i_rd_addr (captured in N), o_sram_oe_n=0, o_sram_we_n=1, o_sram_dq_oe=0.
  - i_sram_dq_in is registered at the end of N+1, giving o_rd_data and o_rd_valid=1 in N+2.
  - Read latency is 2 cycles; back-to-back reads give back-to-back valids.
- Idle cycle: o_sram_we_n=1, o_sram_oe_n=1, o_sram_dq_oe=0; address holds its last value.
- Level update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- No bypass: a write pushed into an empty FIFO in cycle N is popped no earlier than N+1 and appears on the SRAM port in N+2.
- Pointers wrap modulo FIFO_DEPTH.
- Write ordering is preserved (FIFO order), including when writes are interleaved with reads.
- Flush state machine:
  - S_IDLE --i_frame_done--> S_DRAIN.
  - S_DRAIN --(level==0, no pop this cycle, and no write op being driven on the port)--> S_DONE.
  - S_DONE --> S_IDLE unconditionally.
  - o_flush_done=1 only in S_DONE.
  - i_frame_done in S_DRAIN or S_DONE is ignored.
  - Pushes are accepted in every state.
  - If i_frame_done arrives with the FIFO empty and the port idle, o_flush_done asserts 2 cycles later.
- Continuous i_rd_req starves writes; the FIFO fills and back-pressures the encoder. This is intended; the display controller guarantees blanking gaps.

Test Plan:
- Reset release with idle inputs -> o_wr_ready=1, o_fifo_level=0, we_n=oe_n=1, dq_oe=0; no outputs toggle for 10 cycles.
- Single push addr=0x00010, data=0xABCD at cycle 0 -> cycle 2: we_n=0, sram_addr=0x00010, dq_out=0xABCD, dq_oe=1; cycle 3: we_n=1, level=0.
- Read request addr=0x00020 at cycle 0 with the SRAM model returning 0x1234 -> cycle 1: oe_n=0, addr=0x00020; cycle 2: o_rd_valid=1, o_rd_data=0x1234.
- i_rd_req held 12 cycles while the encoder pushes every cycle -> level reaches 8, o_wr_ready=0, no write strobes; after i_rd_req drops, 8 consecutive writes in push order with no pixel lost.
- Push 3 writes then pulse i_frame_done -> o_flush_done pulses exactly once, one cycle after the third write strobe completes; a second i_frame_done during drain has no effect.
- Assert i_rst_n=0 with level=5 and a read in flight -> level=0 immediately, no o_rd_valid, all SRAM strobes inactive.

Source files
------------

// File: rtl/sram_write_buffer.sv
// Buffers encoded pixel writes in a small FIFO and shares one async SRAM port
// with display reads (reads win). Reports when a finished frame has reached SRAM.
module sram_write_buffer #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_frame_done,
  input  logic                  i_rd_req,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_flush_done,
  output logic [CNT_WIDTH-1:0]  o_fifo_level,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic [DATA_WIDTH-1:0] o_sram_dq_out,
  output logic                  o_sram_dq_oe,
  input  logic [DATA_WIDTH-1:0] i_sram_dq_in,
  output logic                  o_sram_we_n,
  output logic                  o_sram_oe_n,
  output logic                  o_sram_ce_n,
  output logic                  o_sram_lb_n,
  output logic                  o_sram_ub_n
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} state_e;

  logic [ADDR_WIDTH-1:0] mem_addr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  level_q, level_d;
  logic                  push, pop;

  logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_WIDTH-1:0] sram_dq_out_q, sram_dq_out_d;
  logic                  sram_dq_oe_q, sram_dq_oe_d;
  logic                  sram_we_n_q, sram_we_n_d;
  logic                  sram_oe_n_q, sram_oe_n_d;
  logic                  sram_en_n_q;
  logic                  rd_pend_q, rd_pend_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  state_e                state_q, state_d;
  logic                  flush_done_q, flush_done_d;

  assign o_wr_ready = (level_q != CNT_WIDTH'(FIFO_DEPTH));
  assign push       = i_wr_valid && o_wr_ready;
  // Pop decisions use the registered level, so a fresh push is never bypassed.
  assign pop        = !i_rd_req && (level_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= i_wr_addr;
      mem_data_q[wr_ptr_q] <= i_wr_data;
    end
  end

  // Port arbiter: decision in cycle N is driven on the pins in N+1.
  always_comb begin
    sram_addr_d   = sram_addr_q;
    sram_dq_out_d = sram_dq_out_q;
    sram_dq_oe_d  = 1'b0;
    sram_we_n_d   = 1'b1;
    sram_oe_n_d   = 1'b1;
    rd_pend_d     = 1'b0;
    if (i_rd_req) begin
      sram_addr_d = i_rd_addr;
      sram_oe_n_d = 1'b0;
      rd_pend_d   = 1'b1;
    end else if (pop) begin
      sram_addr_d   = mem_addr_q[rd_ptr_q];
      sram_dq_out_d = mem_data_q[rd_ptr_q];
      sram_dq_oe_d  = 1'b1;
      sram_we_n_d   = 1'b0;
    end
  end

  // Read data is captured at the end of the cycle the read is on the pins.
  always_comb begin
    rd_valid_d = rd_pend_q;
    rd_data_d  = rd_pend_q ? i_sram_dq_in : rd_data_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_frame_done) state_d = S_DRAIN;
      S_DRAIN: if ((level_q == '0) && !pop && sram_we_n_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    flush_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      sram_addr_q   <= '0;
      sram_dq_out_q <= '0;
      sram_dq_oe_q  <= 1'b0;
      sram_we_n_q   <= 1'b1;
      sram_oe_n_q   <= 1'b1;
      sram_en_n_q   <= 1'b1;
      rd_pend_q     <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      state_q       <= S_IDLE;
      flush_done_q  <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      sram_addr_q   <= sram_addr_d;
      sram_dq_out_q <= sram_dq_out_d;
      sram_dq_oe_q  <= sram_dq_oe_d;
      sram_we_n_q   <= sram_we_n_d;
      sram_oe_n_q   <= sram_oe_n_d;
      sram_en_n_q   <= 1'b0;
      rd_pend_q     <= rd_pend_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
      state_q       <= state_d;
      flush_done_q  <= flush_done_d;
    end
  end

  assign o_fifo_level  = level_q;
  assign o_rd_data     = rd_data_q;
  assign o_rd_valid    = rd_valid_q;
  assign o_flush_done  = flush_done_q;
  assign o_sram_addr   = sram_addr_q;
  assign o_sram_dq_out = sram_dq_out_q;
  assign o_sram_dq_oe  = sram_dq_oe_q;
  assign o_sram_we_n   = sram_we_n_q;
  assign o_sram_oe_n   = sram_oe_n_q;
  assign o_sram_ce_n   = sram_en_n_q;
  assign o_sram_lb_n   = sram_en_n_q;
  assign o_sram_ub_n   = sram_en_n_q;

endmodule

// File: tb/tb_sram_write_buffer.sv
// Scoreboard bench for sram_write_buffer: queued writes/reads are matched
// against what appears on the SRAM port and the read-return path.
module tb_sram_write_buffer;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_wr_valid = 1'b0;
  logic        o_wr_ready;
  logic [19:0] i_wr_addr = '0;
  logic [15:0] i_wr_data = '0;
  logic        i_frame_done = 1'b0;
  logic        i_rd_req = 1'b0;
  logic [19:0] i_rd_addr = '0;
  logic [15:0] o_rd_data;
  logic        o_rd_valid;
  logic        o_flush_done;
  logic [3:0]  o_fifo_level;
  logic [19:0] o_sram_addr;
  logic [15:0] o_sram_dq_out;
  logic        o_sram_dq_oe;
  logic [15:0] i_sram_dq_in;
  logic        o_sram_we_n, o_sram_oe_n, o_sram_ce_n, o_sram_lb_n, o_sram_ub_n;

  sram_write_buffer dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_frame_done(i_frame_done),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
    .o_flush_done(o_flush_done), .o_fifo_level(o_fifo_level),
    .o_sram_addr(o_sram_addr), .o_sram_dq_out(o_sram_dq_out),
    .o_sram_dq_oe(o_sram_dq_oe), .i_sram_dq_in(i_sram_dq_in),
    .o_sram_we_n(o_sram_we_n), .o_sram_oe_n(o_sram_oe_n),
    .o_sram_ce_n(o_sram_ce_n), .o_sram_lb_n(o_sram_lb_n),
    .o_sram_ub_n(o_sram_ub_n)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] rd_fn(input logic [19:0] a);
    return (a == 20'h00020) ? 16'h1234 : (a[15:0] ^ 16'hC3C3);
  endfunction

  // SRAM read model: data appears on DQ while OE_n is low
  assign i_sram_dq_in = !o_sram_oe_n ? rd_fn(o_sram_addr) : 16'h0000;

  typedef struct packed { logic [19:0] a; logic [15:0] d; } wr_t;
  typedef struct packed { logic [15:0] d; int c; } rd_t;
  wr_t pend_q[$];
  wr_t exp_wr_q[$];
  rd_t exp_rd_q[$];

  int last_push = 0, last_strobe = 0, strobes = 0;
  int flush_cnt = 0, flush_cyc = 0, max_lvl = 0;
  logic        prev_rd = 1'b0;
  logic [19:0] prev_rd_addr = '0;

  // Encoder model: presents the head pixel and holds it until accepted
  always @(posedge i_clk) begin
    #1;
    if (pend_q.size() > 0) begin
      i_wr_valid = 1'b1;
      i_wr_addr  = pend_q[0].a;
      i_wr_data  = pend_q[0].d;
    end else begin
      i_wr_valid = 1'b0;
    end
  end

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (i_wr_valid && o_wr_ready && pend_q.size() > 0) begin
        exp_wr_q.push_back(pend_q.pop_front());
        last_push = cyc;
      end
      if (i_rd_req) exp_rd_q.push_back('{rd_fn(i_rd_addr), cyc + 2});
      if (prev_rd) begin
        chk("rd_oe_n", o_sram_oe_n, 1'b0);
        chk("rd_we_n", o_sram_we_n, 1'b1);
        chk("rd_addr", o_sram_addr, prev_rd_addr);
      end
      if (!o_sram_we_n) begin
        chk("wr_expected", exp_wr_q.size() != 0, 1'b1);
        if (exp_wr_q.size() != 0) begin
          wr_t e;
          e = exp_wr_q.pop_front();
          chk("wr_addr", o_sram_addr, e.a);
          chk("wr_data", o_sram_dq_out, e.d);
          chk("wr_dq_oe", o_sram_dq_oe, 1'b1);
          chk("wr_oe_n", o_sram_oe_n, 1'b1);
        end
        strobes++;
        last_strobe = cyc;
      end else begin
        chk("nowr_dq_oe", o_sram_dq_oe, 1'b0);
      end
      if (o_rd_valid) begin
        chk("rd_expected", exp_rd_q.size() != 0, 1'b1);
        if (exp_rd_q.size() != 0) begin
          rd_t r;
          r = exp_rd_q.pop_front();
          chk("rd_data", o_rd_data, r.d);
          chk("rd_latency", cyc, r.c);
        end
      end else if (exp_rd_q.size() != 0 && exp_rd_q[0].c <= cyc) begin
        chk("rd_valid_due", o_rd_valid, 1'b1);
        void'(exp_rd_q.pop_front());
      end
      if (o_flush_done) begin
        flush_cnt++;
        flush_cyc = cyc;
      end
      if (int'(o_fifo_level) > max_lvl) max_lvl = int'(o_fifo_level);
      prev_rd      = i_rd_req;
      prev_rd_addr = i_rd_addr;
    end else begin
      prev_rd = 1'b0;
    end
  end

  task automatic wait_drain(input int limit, input string tag);
    bit done = 0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge i_clk);
      if (pend_q.size() == 0 && exp_wr_q.size() == 0 && exp_rd_q.size() == 0) done = 1;
    end
    chk(tag, done, 1'b1);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd_cyc, sb;
    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_level", o_fifo_level, 4'd0);
    chk("rst_ready", o_wr_ready, 1'b1);
    chk("rst_we_n", o_sram_we_n, 1'b1);
    chk("rst_oe_n", o_sram_oe_n, 1'b1);
    chk("rst_dq_oe", o_sram_dq_oe, 1'b0);
    chk("rst_ce_lb_ub", {o_sram_ce_n, o_sram_lb_n, o_sram_ub_n}, 3'b111);
    chk("rst_addr", o_sram_addr, 20'h0);
    chk("rst_dq_out", o_sram_dq_out, 16'h0);
    chk("rst_rd", {o_rd_valid, o_rd_data}, 17'h0);
    chk("rst_flush", o_flush_done, 1'b0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (10) begin
      @(negedge i_clk);
      chk("idle_strobes", {o_sram_we_n, o_sram_oe_n, o_sram_dq_oe}, 3'b110);
      chk("idle_en", {o_sram_ce_n, o_sram_lb_n, o_sram_ub_n}, 3'b000);
      chk("idle_ready", o_wr_ready, 1'b1);
      chk("idle_flush", {o_flush_done, o_rd_valid}, 2'b00);
    end

    // Single push: strobe two cycles after acceptance, level back to 0
    pend_q.push_back('{20'h00010, 16'hABCD});
    wait_drain(30, "single_push_drain");
    chk("single_push_latency", last_strobe - last_push, 2);
    @(negedge i_clk);
    chk("single_push_level", o_fifo_level, 4'd0);
    chk("single_push_we_off", o_sram_we_n, 1'b1);

    // Single read and a back-to-back burst
    tick();
    i_rd_req = 1'b1; i_rd_addr = 20'h00020;
    tick();
    i_rd_req = 1'b0;
    wait_drain(10, "single_read_drain");
    tick();
    for (int i = 0; i < 4; i++) begin
      i_rd_req = 1'b1; i_rd_addr = 20'h00100 + 20'(i);
      tick();
    end
    i_rd_req = 1'b0;
    wait_drain(10, "burst_read_drain");

    // Reads starve writes; FIFO fills and back-pressures, nothing lost
    tick();
    sb = strobes;
    max_lvl = 0;
    for (int i = 0; i < 12; i++) pend_q.push_back('{20'h00200 + 20'(i), 16'($urandom)});
    i_rd_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      i_rd_addr = 20'h00300 + 20'(i);
      tick();
    end
    chk("starve_max_level", max_lvl, 8);
    chk("starve_ready", o_wr_ready, 1'b0);
    chk("starve_no_writes", strobes - sb, 0);
    i_rd_req = 1'b0;
    wait_drain(60, "starve_drain");
    chk("starve_all_written", strobes - sb, 12);

    // Random interleave of reads and writes
    for (int i = 0; i < 24; i++) pend_q.push_back('{20'h00400 + 20'(i), 16'($urandom)});
    for (int i = 0; i < 50; i++) begin
      i_rd_req  = ($urandom_range(0, 2) == 0);
      i_rd_addr = 20'($urandom);
      tick();
    end
    i_rd_req = 1'b0;
    wait_drain(80, "mix_drain");

    // Flush after three writes; a second frame_done during drain is ignored
    repeat (3) tick();
    flush_cnt = 0;
    for (int i = 0; i < 3; i++) pend_q.push_back('{20'h00500 + 20'(i), 16'h5000 + 16'(i)});
    for (int i = 0; i < 20 && pend_q.size() != 0; i++) @(negedge i_clk);
    chk("flush_pushes_taken", pend_q.size(), 0);
    tick();
    i_frame_done = 1'b1;
    tick();
    i_frame_done = 1'b1;
    tick();
    i_frame_done = 1'b0;
    repeat (12) @(negedge i_clk);
    chk("flush_once", flush_cnt, 1);
    chk("flush_after_last_write", flush_cyc - last_strobe, 2);

    // Flush with nothing pending: two cycles after frame_done
    flush_cnt = 0;
    tick();
    i_frame_done = 1'b1; fd_cyc = cyc;
    tick();
    i_frame_done = 1'b0;
    repeat (6) @(negedge i_clk);
    chk("flush_empty_once", flush_cnt, 1);
    chk("flush_empty_latency", flush_cyc - fd_cyc, 2);

    // Reset with level 5 and a read in flight
    tick();
    i_rd_req = 1'b1; i_rd_addr = 20'h00777;
    for (int i = 0; i < 5; i++) pend_q.push_back('{20'h00600 + 20'(i), 16'h6000 + 16'(i)});
    repeat (8) tick();
    chk("pre_rst_level", o_fifo_level, 4'd5);
    i_rd_req = 1'b0;
    tick();
    #2;
    i_rst_n = 1'b0;
    pend_q.delete();
    exp_wr_q.delete();
    exp_rd_q.delete();
    #1;
    chk("midrst_level", o_fifo_level, 4'd0);
    chk("midrst_strobes", {o_sram_we_n, o_sram_oe_n, o_sram_dq_oe}, 3'b110);
    chk("midrst_en", {o_sram_ce_n, o_sram_lb_n, o_sram_ub_n}, 3'b111);
    chk("midrst_rd_valid", o_rd_valid, 1'b0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    sb = strobes;
    repeat (6) begin
      @(negedge i_clk);
      chk("post_rst_rd_valid", o_rd_valid, 1'b0);
    end
    chk("post_rst_no_writes", strobes - sb, 0);
    chk("post_rst_ready", o_wr_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
